// File: rtl/rx_bit_sequencer.sv
// ---------------------------------------------------------------------------
// rx_bit_sequencer
//
// Receive-side bit sequencer for the UART RX core. Synchronises the serial
// line, times every bit with a 16x oversampling counter advanced by the baud
// tick, and resolves each start, data, parity and stop bit by a 2-of-3
// majority vote over the three samples taken just before the acquisition
// point.
//
// Parameters
//   DATA_BITS        data bits per frame (5..8)
//   ACQSITION_POINT  counter value at which a bit is resolved
//   STOP_EXIT_POINT  counter value in STOPBIT at which the block goes IDLE
//
// Ports
//   clk               system clock
//   rst               asynchronous reset, active low
//   rx_i              raw serial line (asynchronous, idles high)
//   p_BaudSig_i       16x-baud enable, one clk wide per tick
//   p_ParityEnable_i  frame carries a parity bit
//   State_o           one-hot receive state
//   BitWidthCnt_o     oversample position within the current bit
//   Bit_o             last resolved data/parity bit
//   Bit_Synch_o       one-clk strobe: Bit_o has just been updated
//   p_FrameError_o    stop bit resolved low in the current/last frame
//   p_FalseStart_o    one-clk pulse: start bit rejected
// ---------------------------------------------------------------------------
module rx_bit_sequencer #(
    parameter int         DATA_BITS       = 8,
    parameter logic [3:0] ACQSITION_POINT = 4'd7,
    parameter logic [3:0] STOP_EXIT_POINT = 4'd11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    input  logic       p_BaudSig_i,
    input  logic       p_ParityEnable_i,
    output logic [4:0] State_o,
    output logic [3:0] BitWidthCnt_o,
    output logic       Bit_o,
    output logic       Bit_Synch_o,
    output logic       p_FrameError_o,
    output logic       p_FalseStart_o
);

    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        STARTBIT  = 5'b00010,
        DATABITS  = 5'b00100,
        PARITYBIT = 5'b01000,
        STOPBIT   = 5'b10000
    } rx_state_t;

    // The two early votes are taken on the two ticks preceding the
    // acquisition tick; the third vote is the live synchronised line.
    localparam logic [3:0] SAMPLE_A = ACQSITION_POINT - 4'd2;
    localparam logic [3:0] SAMPLE_B = ACQSITION_POINT - 4'd1;
    localparam logic [3:0] CNT_LAST = 4'd15;
    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    rx_state_t  state;
    logic [3:0] cnt;
    logic [2:0] bit_idx;
    logic       sample_a;
    logic       sample_b;
    logic       rx_meta;
    logic       rx_s;
    logic       majority;

    // Two-flop synchroniser; resets to the idle line level so no false
    // start is seen coming out of reset.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    assign majority = (sample_a & sample_b) | (sample_a & rx_s) | (sample_b & rx_s);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            bit_idx        <= 3'd0;
            sample_a       <= 1'b1;
            sample_b       <= 1'b1;
            Bit_o          <= 1'b1;
            Bit_Synch_o    <= 1'b0;
            p_FrameError_o <= 1'b0;
            p_FalseStart_o <= 1'b0;
        end else begin
            // NOTE: the strobes default low on every clk, not every tick, so
            // they stay one clk wide even when p_BaudSig_i is held high.
            Bit_Synch_o    <= 1'b0;
            p_FalseStart_o <= 1'b0;

            if (p_BaudSig_i) begin
                if (state != IDLE) begin
                    if (cnt == SAMPLE_A) sample_a <= rx_s;
                    if (cnt == SAMPLE_B) sample_b <= rx_s;
                end

                unique case (state)
                    IDLE: begin
                        cnt <= 4'd0;
                        if (!rx_s) begin
                            state          <= STARTBIT;
                            p_FrameError_o <= 1'b0;
                        end
                    end

                    STARTBIT: begin
                        if (cnt == ACQSITION_POINT && majority) begin
                            state          <= IDLE;
                            cnt            <= 4'd0;
                            p_FalseStart_o <= 1'b1;
                        end else if (cnt == CNT_LAST) begin
                            state   <= DATABITS;
                            cnt     <= 4'd0;
                            bit_idx <= 3'd0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end

                    DATABITS: begin
                        // 15 + 1 wraps to 0, which is also the start of the
                        // next bit, so the counter needs no special case here.
                        cnt <= cnt + 4'd1;
                        if (cnt == ACQSITION_POINT) begin
                            Bit_o       <= majority;
                            Bit_Synch_o <= 1'b1;
                        end
                        if (cnt == CNT_LAST) begin
                            if (bit_idx != LAST_IDX) begin
                                bit_idx <= bit_idx + 3'd1;
                            end else if (p_ParityEnable_i) begin
                                state <= PARITYBIT;
                            end else begin
                                state <= STOPBIT;
                            end
                        end
                    end

                    PARITYBIT: begin
                        cnt <= cnt + 4'd1;
                        if (cnt == ACQSITION_POINT) begin
                            Bit_o       <= majority;
                            Bit_Synch_o <= 1'b1;
                        end
                        if (cnt == CNT_LAST) state <= STOPBIT;
                    end

                    STOPBIT: begin
                        // The stop bit is judged but not strobed downstream.
                        if (cnt == ACQSITION_POINT && !majority) p_FrameError_o <= 1'b1;
                        // Leaving before the end of the stop bit gives a fast
                        // transmitter's next start edge room to be caught.
                        if (cnt == STOP_EXIT_POINT) begin
                            state <= IDLE;
                            cnt   <= 4'd0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign State_o       = state;
    assign BitWidthCnt_o = cnt;

endmodule

// File: tb/tb_rx_bit_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rx_bit_sequencer
//
// Directed bench for rx_bit_sequencer. A tick every 4 clk drives the baud
// enable; a small transmitter shapes rx_i in whole ticks, and a negedge
// monitor records strobes, state changes and per-state tick counts.
// ---------------------------------------------------------------------------
module tb_rx_bit_sequencer;

    localparam logic [4:0] S_IDLE   = 5'b00001;
    localparam logic [4:0] S_START  = 5'b00010;
    localparam logic [4:0] S_DATA   = 5'b00100;
    localparam logic [4:0] S_PARITY = 5'b01000;
    localparam logic [4:0] S_STOP   = 5'b10000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_i = 1'b1;
    logic       p_BaudSig_i = 1'b0;
    logic       p_ParityEnable_i = 1'b0;
    logic [4:0] State_o;
    logic [3:0] BitWidthCnt_o;
    logic       Bit_o;
    logic       Bit_Synch_o;
    logic       p_FrameError_o;
    logic       p_FalseStart_o;

    rx_bit_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .rx_i             (rx_i),
        .p_BaudSig_i      (p_BaudSig_i),
        .p_ParityEnable_i (p_ParityEnable_i),
        .State_o          (State_o),
        .BitWidthCnt_o    (BitWidthCnt_o),
        .Bit_o            (Bit_o),
        .Bit_Synch_o      (Bit_Synch_o),
        .p_FrameError_o   (p_FrameError_o),
        .p_FalseStart_o   (p_FalseStart_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor state
    int         div = 0;
    logic       bits_q[$];
    logic [4:0] strobe_state_q[$];
    logic [3:0] strobe_cnt_q[$];
    logic [4:0] state_q[$];
    logic [4:0] last_state = 5'b00001;
    int         busy_ticks = 0;
    int         parity_ticks = 0;
    int         fs_count = 0;
    int         pulse_long = 0;
    logic       prev_synch = 1'b0;
    logic       prev_fs = 1'b0;
    logic       prev_fe = 1'b0;
    logic [4:0] fe_rise_state = 5'b0;
    logic [3:0] fe_rise_cnt = 4'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Baud enable changes on negedge so it is stable at the DUT's posedge;
    // a tick is counted against the state the DUT is in when it arrives.
    always @(negedge clk) begin
        div = (div == 3) ? 0 : div + 1;
        p_BaudSig_i = (div == 0);
        if (p_BaudSig_i) begin
            if (State_o != S_IDLE)   busy_ticks++;
            if (State_o == S_PARITY) parity_ticks++;
        end
        if (Bit_Synch_o) begin
            bits_q.push_back(Bit_o);
            strobe_state_q.push_back(State_o);
            strobe_cnt_q.push_back(BitWidthCnt_o);
            if (prev_synch) pulse_long++;
        end
        if (p_FalseStart_o) begin
            fs_count++;
            if (prev_fs) pulse_long++;
        end
        if (p_FrameError_o && !prev_fe) begin
            fe_rise_state = State_o;
            fe_rise_cnt   = BitWidthCnt_o;
        end
        if (State_o != last_state) begin
            state_q.push_back(State_o);
            last_state = State_o;
        end
        prev_synch = Bit_Synch_o;
        prev_fs    = p_FalseStart_o;
        prev_fe    = p_FrameError_o;
    end

    function automatic logic get_bit(input int i);
        return (i < bits_q.size()) ? bits_q[i] : 1'bx;
    endfunction

    function automatic logic [4:0] get_strobe_state(input int i);
        return (i < strobe_state_q.size()) ? strobe_state_q[i] : 5'bx;
    endfunction

    function automatic logic [3:0] get_strobe_cnt(input int i);
        return (i < strobe_cnt_q.size()) ? strobe_cnt_q[i] : 4'bx;
    endfunction

    function automatic logic [4:0] get_state(input int i);
        return (i < state_q.size()) ? state_q[i] : 5'bx;
    endfunction

    task automatic clear_monitor();
        bits_q.delete();
        strobe_state_q.delete();
        strobe_cnt_q.delete();
        state_q.delete();
        last_state   = State_o;
        busy_ticks   = 0;
        parity_ticks = 0;
        fs_count     = 0;
        fe_rise_state = 5'b0;
        fe_rise_cnt   = 4'b0;
    endtask

    // Returns 1 time unit after a tick edge, so rx_i never changes on an edge.
    task automatic wait_tick();
        do @(posedge clk); while (p_BaudSig_i !== 1'b1);
        #1;
    endtask

    task automatic tx_level(input logic v, input int n);
        rx_i = v;
        repeat (n) wait_tick();
    endtask

    // Start, 8 data bits LSB first, optional parity, stop of given length.
    // glitch_bit >= 0 puts a 1-tick high pulse at offset 7 of that data bit,
    // which lands on the DUT's cnt==6 sample.
    task automatic send_frame(input logic [7:0] d, input bit par_en, input logic par_v,
                              input logic stop_v, input int stop_ticks, input int glitch_bit);
        tx_level(1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                tx_level(1'b0, 7);
                tx_level(1'b1, 1);
                tx_level(1'b0, 8);
            end else begin
                tx_level(d[i], 16);
            end
        end
        if (par_en) tx_level(par_v, 16);
        tx_level(stop_v, stop_ticks);
        rx_i = 1'b1;
    endtask

    task automatic check_bits(input string tag, input logic [7:0] exp, input int offset);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_bit%0d", tag, i), 32'(get_bit(offset + i)), 32'(exp[i]));
    endtask

    initial begin
        // ---------------- reset values ----------------
        repeat (3) @(posedge clk);
        #2;
        check("rst_state",  32'(State_o),        32'(S_IDLE));
        check("rst_cnt",    32'(BitWidthCnt_o),  32'd0);
        check("rst_bit",    32'(Bit_o),          32'd1);
        check("rst_synch",  32'(Bit_Synch_o),    32'd0);
        check("rst_ferr",   32'(p_FrameError_o), 32'd0);
        check("rst_fstart", 32'(p_FalseStart_o), 32'd0);
        rst = 1'b1;
        wait_tick();
        tx_level(1'b1, 8);

        // ---------------- 8N1 frame 0xA5 ----------------
        p_ParityEnable_i = 1'b0;
        clear_monitor();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 16, -1);
        tx_level(1'b1, 4);
        check("a5_strobes", bits_q.size(), 32'd8);
        check_bits("a5", 8'hA5, 0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("a5_strobe_cnt%0d", i), 32'(get_strobe_cnt(i)), 32'd8);
            check($sformatf("a5_strobe_state%0d", i), 32'(get_strobe_state(i)), 32'(S_DATA));
        end
        check("a5_nstates", state_q.size(), 32'd4);
        check("a5_state0", 32'(get_state(0)), 32'(S_START));
        check("a5_state1", 32'(get_state(1)), 32'(S_DATA));
        check("a5_state2", 32'(get_state(2)), 32'(S_STOP));
        check("a5_state3", 32'(get_state(3)), 32'(S_IDLE));
        check("a5_ferr",   32'(p_FrameError_o), 32'd0);
        check("a5_ticks",  busy_ticks, 32'd156);

        // ---------------- 8E1 frame 0x03, parity 0 ----------------
        p_ParityEnable_i = 1'b1;
        clear_monitor();
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 16, -1);
        tx_level(1'b1, 4);
        p_ParityEnable_i = 1'b0;
        check("par_strobes", bits_q.size(), 32'd9);
        check_bits("par", 8'h03, 0);
        check("par_bit",        32'(get_bit(8)),          32'd0);
        check("par_bit_state",  32'(get_strobe_state(8)), 32'(S_PARITY));
        check("par_state_ticks", parity_ticks, 32'd16);
        check("par_ticks",      busy_ticks, 32'd172);

        // ---------------- false start ----------------
        clear_monitor();
        tx_level(1'b0, 3);
        tx_level(1'b1, 20);
        check("fs_nstates", state_q.size(), 32'd2);
        check("fs_state0",  32'(get_state(0)), 32'(S_START));
        check("fs_state1",  32'(get_state(1)), 32'(S_IDLE));
        check("fs_pulses",  fs_count, 32'd1);
        check("fs_strobes", bits_q.size(), 32'd0);
        check("fs_ticks",   busy_ticks, 32'd8);

        // ---------------- frame error ----------------
        // Stop bit low for 10 ticks covers the votes but ends before the
        // exit point, so the low line cannot look like a new start.
        clear_monitor();
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 10, -1);
        tx_level(1'b1, 20);
        check("fe_flag",       32'(p_FrameError_o), 32'd1);
        check("fe_idle",       32'(State_o),        32'(S_IDLE));
        check("fe_rise_state", 32'(fe_rise_state),  32'(S_STOP));
        check("fe_rise_cnt",   32'(fe_rise_cnt),    32'd8);
        tx_level(1'b0, 3);
        check("fe_next_start", 32'(State_o),        32'(S_START));
        check("fe_cleared",    32'(p_FrameError_o), 32'd0);
        tx_level(1'b0, 13);
        for (int i = 0; i < 8; i++) tx_level(1'b1, 16);
        tx_level(1'b1, 20);
        check("fe_clean_ferr", 32'(p_FrameError_o), 32'd0);

        // ---------------- noise + back-to-back ----------------
        clear_monitor();
        send_frame(8'h00, 1'b0, 1'b0, 1'b1, 12, 2);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 16, -1);
        tx_level(1'b1, 4);
        check("b2b_strobes", bits_q.size(), 32'd16);
        check_bits("glitch", 8'h00, 0);
        check_bits("b2b", 8'hC3, 8);
        check("b2b_ferr", 32'(p_FrameError_o), 32'd0);

        // ---------------- reset mid-frame ----------------
        clear_monitor();
        tx_level(1'b0, 16);
        for (int i = 0; i < 4; i++) tx_level(i < 3, 16);  // 0x37 bits 0..3
        tx_level(1'b1, 5);                                // part of bit 4
        check("mid_state",   32'(State_o), 32'(S_DATA));
        check("mid_bit",     32'(Bit_o),   32'd0);
        check("mid_strobes", bits_q.size(), 32'd4);
        #2 rst = 1'b0;
        #1;
        check("mrst_state",  32'(State_o),        32'(S_IDLE));
        check("mrst_cnt",    32'(BitWidthCnt_o),  32'd0);
        check("mrst_bit",    32'(Bit_o),          32'd1);
        check("mrst_synch",  32'(Bit_Synch_o),    32'd0);
        check("mrst_ferr",   32'(p_FrameError_o), 32'd0);
        check("mrst_fstart", 32'(p_FalseStart_o), 32'd0);
        rx_i = 1'b1;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        wait_tick();
        tx_level(1'b1, 8);
        check("mrst_no_strobe", bits_q.size(), 32'd4);
        clear_monitor();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 16, -1);
        tx_level(1'b1, 4);
        check("post_strobes", bits_q.size(), 32'd8);
        check_bits("post", 8'h5A, 0);
        check("post_state", 32'(State_o), 32'(S_IDLE));

        check("pulse_width", pulse_long, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_bit_sequencer.md
# rx_bit_sequencer

Receive-side bit sequencer for the UART RX core. It synchronises the serial line, times each bit with a 16x oversampling counter driven by the baud tick, and recovers each data and parity bit by majority vote. It publishes the one-hot receive state, the bit-width counter, a per-bit strobe and a frame-error flag. It sits directly upstream of the shift register and byte-analysis stage, which consume `State_o`, `BitWidthCnt_o`, `Bit_o` and `Bit_Synch_o`.

## Interface
- `DATA_BITS`, 8 — data bits per frame; legal range 5..8.
- `ACQSITION_POINT`, 4'd7 — counter value at which a bit is resolved.
- `STOP_EXIT_POINT`, 4'd11 — counter value in STOPBIT at which the block returns to IDLE.
- `clk` input 1 — system clock; the only clock.
- `rst` input 1 — asynchronous, active-low reset.
- `rx_i` input 1 — raw serial line, asynchronous to `clk`; idles high.
- `p_BaudSig_i` input 1 — 16x-baud enable; one `clk` per tick.
- `p_ParityEnable_i` input 1 — frame carries a parity bit.
- `State_o` output 5 — one-hot state: IDLE 00001, STARTBIT 00010, DATABITS 00100, PARITYBIT 01000, STOPBIT 10000.
- `BitWidthCnt_o` output 4 — oversample position within the current bit.
- `Bit_o` output 1 — last resolved bit value.
- `Bit_Synch_o` output 1 — one-`clk` strobe; `Bit_o` is new.
- `p_FrameError_o` output 1 — stop bit sampled low in the current frame.
- `p_FalseStart_o` output 1 — one-`clk` pulse; start bit rejected.

## Operation
- `rx_i` passes through a 2-flop synchroniser (`rx_s`), reset value 1.
- All counter and state activity happens only on `clk` edges where `p_BaudSig_i` is 1 ("tick"). Between ticks, everything holds.
- **Counter:** on each tick outside IDLE, `BitWidthCnt_o` increments and wraps from 15 to 0. A state transition forces it to 0. In IDLE it holds at 0.
- **IDLE:** on a tick with `rx_s==0`, go to STARTBIT with cnt=0. Clear `p_FrameError_o` on this transition.
- **STARTBIT:** on the tick with cnt==ACQSITION_POINT, resolve the bit by majority.
  - If the result is 1: go to IDLE, cnt=0, and pulse `p_FalseStart_o`.
  - Otherwise, on the tick with cnt==15: go to DATABITS with bit index 0.
- **Majority vote:** `rx_s` is captured on ticks with cnt==5 and cnt==6. On the cnt==7 tick, the result is majority(s5, s6, `rx_s`).
- **DATABITS:** on the cnt==7 tick, register the majority into `Bit_o` and assert `Bit_Synch_o` for exactly one `clk`. On the cnt==15 tick:
  - If index < DATA_BITS-1: increment the index and stay in DATABITS.
  - Else: go to PARITYBIT if `p_ParityEnable_i` is 1, otherwise go to STOPBIT.
  - `p_ParityEnable_i` is sampled only at this transition.
- **PARITYBIT:** same sampling and strobe as DATABITS. On the cnt==15 tick, go to STOPBIT.
- **STOPBIT:** on the cnt==7 tick, set `p_FrameError_o` if the majority is 0. It holds until the next IDLE→STARTBIT transition.
  - No `Bit_Synch_o` is generated for the stop bit.
  - On the tick with cnt==STOP_EXIT_POINT, go to IDLE with cnt=0. This leaves margin for a fast transmitter's next start bit.
- **Reset values:** `State_o`=IDLE, `BitWidthCnt_o`=0, `Bit_o`=1, `Bit_Synch_o`=0, `p_FrameError_o`=0, `p_FalseStart_o`=0, bit index=0, samples=1.
- **Reset mid-frame:** outputs return to reset values immediately (asynchronous). No strobe is emitted.
- A low glitch on `rx_s` in IDLE that does not coincide with a tick is ignored.
- A start glitch shorter than 2 of 3 samples is rejected as a false start.

## Timing
- Input latency is 2 `clk` (synchroniser) plus up to 1 tick before the start is detected.
- State, counter and flags update on the tick edge. `Bit_Synch_o` and `Bit_o` are valid in the cycle after the cnt==7 tick, when `BitWidthCnt_o` already reads 8. Downstream judges parity at cnt 8 and latches data at cnt 9.
- `Bit_Synch_o` and `p_FalseStart_o` are never high for more than one `clk`, even if `p_BaudSig_i` stays high.
- Frame length from start detection to IDLE: (1 + DATA_BITS + parity)·16 + STOP_EXIT_POINT + 1 ticks.
  - 8N1: 156 ticks.
  - 8E1: 172 ticks.

## Test plan
- **8N1 frame 0xA5**, LSB first, tick every 4 `clk`. Expect:
  - 8 `Bit_Synch_o` pulses with `Bit_o` = 1,0,1,0,0,1,0,1;
  - state sequence IDLE→STARTBIT→DATABITS→STOPBIT→IDLE;
  - `p_FrameError_o`=0;
  - 156 ticks start to IDLE.
- **Parity enabled, frame 0x03** with parity bit 0. Expect a 9th `Bit_Synch_o` in PARITYBIT with `Bit_o`=0, and PARITYBIT lasting exactly 16 ticks.
- **False start:** `rx_i` low for 3 ticks only. Expect STARTBIT, then IDLE on the cnt==7 tick, one `p_FalseStart_o` pulse, and no `Bit_Synch_o`.
- **Frame error:** stop bit driven low, 0x00 data. Expect `p_FrameError_o`=1 from the STOPBIT cnt==7 tick, held through IDLE, and cleared on the next start.
- **Noise and back-to-back:**
  - A 1-tick high glitch at cnt==6 of data bit 2 of 0x00 is still resolved as 0.
  - A second frame starting at stop cnt 12 is captured correctly.
- **Reset mid-frame:** assert `rst` during DATABITS bit 4. Expect all outputs at reset values immediately and no strobe. A clean frame after release is received correctly.
